// File: rtl/rx_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_pkg
// Purpose  : Shared types and constants for the per-lane RX frame parser.
// Revision : 1.0
// ============================================================================
package rx_frame_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        TSTAMP  = 2'd1,
        PAYLOAD = 2'd2,
        ENDER   = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] BAD_ENDER = 2'd1;
    localparam logic [1:0] SYNC_LOST = 2'd2;
    localparam logic [1:0] CTRL_CHAR = 2'd3;

    localparam int          DEFAULT_PAYLOAD_WORDS = 125;
    localparam logic [15:0] DEFAULT_HEADER_WORD   = 16'hDEAD;
    localparam logic [15:0] DEFAULT_ENDER_WORD    = 16'hBEEF;

endpackage
`default_nettype wire

// File: rtl/sat_counter16.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter16
// Purpose  : 16-bit enable-increment counter that holds at all-ones.
// Revision : 1.0
// ============================================================================
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] count
);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 16'h0000;
        end else if (en && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/rx_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_parser
// Purpose  : Per-lane header/timestamp/payload/ender frame parser with status.
// Revision : 1.0
// ============================================================================
module rx_frame_parser
    import rx_frame_pkg::*;
#(
    parameter int          PAYLOAD_WORDS = DEFAULT_PAYLOAD_WORDS,
    parameter logic [15:0] HEADER_WORD   = DEFAULT_HEADER_WORD,
    parameter logic [15:0] ENDER_WORD    = DEFAULT_ENDER_WORD
) (
    input  logic        clk_trans,
    input  logic        rst,
    input  logic [1:0]  rx_syncstatus,
    input  logic [1:0]  rx_datak,
    input  logic [15:0] rx_parallel_data,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    output logic [15:0] out_timestamp,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        ts_gap,
    output logic [15:0] frame_count,
    output logic [15:0] error_count
);

    localparam int                c_cnt_w    = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(PAYLOAD_WORDS - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_next;

    logic                 w_sync_ok;
    logic                 w_lane_ok;
    logic                 w_abort;

    logic [15:0]          r_data;
    logic                 r_valid;
    logic                 r_sop;
    logic                 r_eop;
    logic [15:0]          r_ts;
    logic                 r_ok;
    logic                 r_err;
    logic [1:0]           r_code;
    logic                 r_gap;
    logic [15:0]          r_prev_ts;
    logic                 r_prev_valid;

    logic [15:0]          w_data;
    logic                 w_valid;
    logic                 w_sop;
    logic                 w_eop;
    logic [15:0]          w_ts_next;
    logic                 w_ok;
    logic                 w_err;
    logic [1:0]           w_code;
    logic                 w_gap;

    assign w_sync_ok = (rx_syncstatus == 2'b11);
    assign w_lane_ok = w_sync_ok && (rx_datak == 2'b00);
    // Any unqualified word outside HUNT kills the frame in progress.
    assign w_abort   = (r_state != HUNT) && !w_lane_ok;

    always_ff @(posedge clk_trans) begin
        if (rst) begin
            r_state <= HUNT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_data       = r_data;
        w_valid      = 1'b0;
        w_sop        = 1'b0;
        w_eop        = 1'b0;
        w_ts_next    = r_ts;
        w_ok         = 1'b0;
        w_err        = 1'b0;
        w_code       = ERR_NONE;
        w_gap        = 1'b0;

        if (w_abort) begin
            w_err        = 1'b1;
            w_code       = w_sync_ok ? CTRL_CHAR : SYNC_LOST;
            w_state_next = HUNT;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                HUNT: begin
                    if (w_lane_ok && (rx_parallel_data == HEADER_WORD)) begin
                        w_state_next = TSTAMP;
                    end
                end
                TSTAMP: begin
                    w_ts_next    = rx_parallel_data;
                    w_cnt_next   = '0;
                    w_state_next = PAYLOAD;
                end
                PAYLOAD: begin
                    w_valid = 1'b1;
                    w_data  = rx_parallel_data;
                    w_sop   = (r_cnt == '0);
                    w_eop   = (r_cnt == c_last_idx);
                    w_gap   = w_sop && r_prev_valid && (r_ts != r_prev_ts + 16'd1);
                    if (r_cnt == c_last_idx) begin
                        w_cnt_next   = '0;
                        w_state_next = ENDER;
                    end else begin
                        w_cnt_next = r_cnt + c_cnt_w'(1);
                    end
                end
                ENDER: begin
                    if (rx_parallel_data == ENDER_WORD) begin
                        w_ok = 1'b1;
                    end else begin
                        w_err  = 1'b1;
                        w_code = BAD_ENDER;
                    end
                    w_state_next = HUNT;
                end
                default: begin
                    w_state_next = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_trans) begin
        if (rst) begin
            r_data       <= 16'h0000;
            r_valid      <= 1'b0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_ts         <= 16'h0000;
            r_ok         <= 1'b0;
            r_err        <= 1'b0;
            r_code       <= ERR_NONE;
            r_gap        <= 1'b0;
            r_prev_ts    <= 16'h0000;
            r_prev_valid <= 1'b0;
        end else begin
            r_data  <= w_data;
            r_valid <= w_valid;
            r_sop   <= w_sop;
            r_eop   <= w_eop;
            r_ts    <= w_ts_next;
            r_ok    <= w_ok;
            r_err   <= w_err;
            r_code  <= w_code;
            r_gap   <= w_gap;
            // Only frames that closed cleanly anchor the continuity check.
            if (w_ok) begin
                r_prev_ts    <= r_ts;
                r_prev_valid <= 1'b1;
            end
        end
    end

    sat_counter16 u_frame_cnt (
        .clk   (clk_trans),
        .rst   (rst),
        .en    (w_ok),
        .count (frame_count)
    );

    sat_counter16 u_error_cnt (
        .clk   (clk_trans),
        .rst   (rst),
        .en    (w_err),
        .count (error_count)
    );

    assign out_data      = r_data;
    assign out_valid     = r_valid;
    assign out_sop       = r_sop;
    assign out_eop       = r_eop;
    assign out_timestamp = r_ts;
    assign frame_ok      = r_ok;
    assign frame_err     = r_err;
    assign err_code      = r_code;
    assign ts_gap        = r_gap;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_frame_parser
// Purpose  : Scoreboard bench for rx_frame_parser frame, status and counters.
// Revision : 1.0
// ============================================================================
module tb_rx_frame_parser;
    import rx_frame_pkg::*;

    localparam int P = 125;

    logic        clk_trans = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rx_syncstatus = 2'b11;
    logic [1:0]  rx_datak = 2'b00;
    logic [15:0] rx_parallel_data = 16'h0000;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic [15:0] out_timestamp;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        ts_gap;
    logic [15:0] frame_count;
    logic [15:0] error_count;

    always #5 clk_trans = ~clk_trans;

    rx_frame_parser #(.PAYLOAD_WORDS(P)) u_dut (
        .clk_trans        (clk_trans),
        .rst              (rst),
        .rx_syncstatus    (rx_syncstatus),
        .rx_datak         (rx_datak),
        .rx_parallel_data (rx_parallel_data),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_sop          (out_sop),
        .out_eop          (out_eop),
        .out_timestamp    (out_timestamp),
        .frame_ok         (frame_ok),
        .frame_err        (frame_err),
        .err_code         (err_code),
        .ts_gap           (ts_gap),
        .frame_count      (frame_count),
        .error_count      (error_count)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        sop;
        logic        eop;
        logic [15:0] ts;
        logic        gap;
    } word_t;

    typedef struct packed {
        logic       ok;
        logic       err;
        logic [1:0] code;
        logic       after_eop;
    } stat_t;

    word_t q_words[$];
    stat_t q_stat[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_words  = 0;
    int n_sop    = 0;
    int n_eop    = 0;
    int n_ok     = 0;
    int n_err    = 0;
    int n_gap    = 0;
    logic last_eop = 1'b0;

    logic [15:0] m_prev_ts    = 16'h0000;
    logic        m_prev_valid = 1'b0;
    int          m_frames     = 0;
    int          m_errs       = 0;

    // Output monitor: every forwarded word and every status pulse is popped
    // from the expectation queues filled by the stimulus tasks.
    always @(negedge clk_trans) begin
        word_t got_w;
        word_t exp_w;
        stat_t got_s;
        stat_t exp_s;
        if (out_valid === 1'b1) begin
            n_words++;
            if (out_sop === 1'b1) n_sop++;
            if (out_eop === 1'b1) n_eop++;
            got_w = {out_data, out_sop, out_eop, out_timestamp, ts_gap};
            n_checks++;
            if (q_words.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word got data=%h want no word", out_data);
            end else begin
                exp_w = q_words.pop_front();
                if (got_w !== exp_w) begin
                    n_fail++;
                    $display("FAIL word got data=%h sop=%b eop=%b ts=%h gap=%b want data=%h sop=%b eop=%b ts=%h gap=%b",
                             got_w.data, got_w.sop, got_w.eop, got_w.ts, got_w.gap,
                             exp_w.data, exp_w.sop, exp_w.eop, exp_w.ts, exp_w.gap);
                end
            end
        end else if (ts_gap === 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL gap_without_word got ts_gap=1 want 0");
        end
        if (ts_gap === 1'b1) n_gap++;
        if ((frame_ok === 1'b1) || (frame_err === 1'b1)) begin
            if (frame_ok === 1'b1) n_ok++;
            if (frame_err === 1'b1) n_err++;
            got_s = {frame_ok, frame_err, (frame_err === 1'b1) ? err_code : 2'b00, last_eop};
            n_checks++;
            if (q_stat.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_status got ok=%b err=%b code=%0d want none",
                         frame_ok, frame_err, err_code);
            end else begin
                exp_s = q_stat.pop_front();
                if (got_s !== exp_s) begin
                    n_fail++;
                    $display("FAIL status got ok=%b err=%b code=%0d after_eop=%b want ok=%b err=%b code=%0d after_eop=%b",
                             got_s.ok, got_s.err, got_s.code, got_s.after_eop,
                             exp_s.ok, exp_s.err, exp_s.code, exp_s.after_eop);
                end
            end
        end
        last_eop = (out_valid === 1'b1) && (out_eop === 1'b1);
    end

    task automatic drive(input logic [15:0] w, input logic [1:0] s, input logic [1:0] k);
        rx_parallel_data = w;
        rx_syncstatus    = s;
        rx_datak         = k;
        @(posedge clk_trans);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(16'h0000, 2'b11, 2'b00);
    endtask

    task automatic model_reset();
        m_prev_valid = 1'b0;
        m_prev_ts    = 16'h0000;
        m_frames     = 0;
        m_errs       = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(16'h0000, 2'b11, 2'b00);
        drive(16'h0000, 2'b11, 2'b00);
        rst = 1'b0;
        model_reset();
    endtask

    // kind: 0 none, 1 sync loss, 2 control char, 3 reset pulse at payload index ab_idx
    task automatic send_frame(input logic [15:0] ts, input int iter, input int mode,
                              input logic [15:0] ender, input int ab_idx, input int kind);
        logic [15:0] w;
        logic        gap;
        word_t       e;
        drive(16'hDEAD, 2'b11, 2'b00);
        drive(ts, 2'b11, 2'b00);
        gap = m_prev_valid && (ts != m_prev_ts + 16'd1);
        for (int i = 0; i < P; i++) begin
            w = {iter[7:0], 8'(i)};
            if (mode == 1) begin
                if (i % 10 == 3) w = 16'hDEAD;
                else if (i % 10 == 7) w = 16'hBEEF;
            end
            if ((kind != 0) && (i == ab_idx)) begin
                if (kind == 1) begin
                    q_stat.push_back({1'b0, 1'b1, SYNC_LOST, 1'b0});
                    m_errs++;
                    drive(w, 2'b01, 2'b00);
                end else if (kind == 2) begin
                    q_stat.push_back({1'b0, 1'b1, CTRL_CHAR, 1'b0});
                    m_errs++;
                    drive(w, 2'b11, 2'b01);
                end else begin
                    rst = 1'b1;
                    drive(w, 2'b11, 2'b00);
                    rst = 1'b0;
                    model_reset();
                end
                idle(21);
                return;
            end
            e = {w, (i == 0), (i == P - 1), ts, (i == 0) && gap};
            q_words.push_back(e);
            drive(w, 2'b11, 2'b00);
        end
        if (ender == 16'hBEEF) begin
            q_stat.push_back({1'b1, 1'b0, ERR_NONE, 1'b1});
            m_prev_ts    = ts;
            m_prev_valid = 1'b1;
            m_frames++;
        end else begin
            q_stat.push_back({1'b0, 1'b1, BAD_ENDER, 1'b1});
            m_errs++;
        end
        drive(ender, 2'b11, 2'b00);
        idle(21);
    endtask

    task automatic check_counters(input string tag);
        n_checks++;
        if (frame_count !== 16'(m_frames)) begin
            n_fail++;
            $display("FAIL %s frame_count got %0d want %0d", tag, frame_count, m_frames);
        end
        n_checks++;
        if (error_count !== 16'(m_errs)) begin
            n_fail++;
            $display("FAIL %s error_count got %0d want %0d", tag, error_count, m_errs);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if ({out_data, out_valid, out_sop, out_eop, out_timestamp} !== 35'd0) begin
            n_fail++;
            $display("FAIL %s stream_outputs got data=%h v=%b sop=%b eop=%b ts=%h want all 0",
                     tag, out_data, out_valid, out_sop, out_eop, out_timestamp);
        end
        n_checks++;
        if ({frame_ok, frame_err, err_code, ts_gap} !== 5'd0) begin
            n_fail++;
            $display("FAIL %s status_outputs got ok=%b err=%b code=%0d gap=%b want all 0",
                     tag, frame_ok, frame_err, err_code, ts_gap);
        end
        n_checks++;
        if ({frame_count, error_count} !== 32'd0) begin
            n_fail++;
            $display("FAIL %s counters got fc=%0d ec=%0d want 0 0", tag, frame_count, error_count);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_all_zero("reset");
    endtask

    task automatic test_clean_frames();
        int w0, s0, e0, g0;
        w0 = n_words; s0 = n_sop; e0 = n_eop; g0 = n_gap;
        send_frame(16'd10, 0, 0, 16'hBEEF, -1, 0);
        send_frame(16'd11, 1, 0, 16'hBEEF, -1, 0);
        send_frame(16'd12, 2, 0, 16'hBEEF, -1, 0);
        n_checks++;
        if ((n_words - w0) !== 375) begin
            n_fail++;
            $display("FAIL clean_words got %0d want 375", n_words - w0);
        end
        n_checks++;
        if ((n_sop - s0) !== 3 || (n_eop - e0) !== 3) begin
            n_fail++;
            $display("FAIL clean_sop_eop got %0d/%0d want 3/3", n_sop - s0, n_eop - e0);
        end
        n_checks++;
        if ((n_gap - g0) !== 0) begin
            n_fail++;
            $display("FAIL clean_gap got %0d want 0", n_gap - g0);
        end
        n_checks++;
        if (frame_count !== 16'd3) begin
            n_fail++;
            $display("FAIL clean_frame_count got %0d want 3", frame_count);
        end
    endtask

    task automatic test_bad_ender();
        int e0;
        do_reset();
        e0 = n_eop;
        send_frame(16'd10, 3, 0, 16'hBEEE, -1, 0);
        n_checks++;
        if ((n_eop - e0) !== 1) begin
            n_fail++;
            $display("FAIL bad_ender_eop got %0d want 1", n_eop - e0);
        end
        n_checks++;
        if (error_count !== 16'd1) begin
            n_fail++;
            $display("FAIL bad_ender_error_count got %0d want 1", error_count);
        end
        send_frame(16'd11, 4, 0, 16'hBEEF, -1, 0);
        check_counters("bad_ender_recover");
    endtask

    task automatic test_sync_lost();
        int w0, e0;
        w0 = n_words; e0 = n_eop;
        send_frame(16'd12, 5, 0, 16'hBEEF, 50, 1);
        n_checks++;
        if ((n_words - w0) !== 50 || (n_eop - e0) !== 0) begin
            n_fail++;
            $display("FAIL sync_lost_words got %0d words %0d eop want 50 words 0 eop",
                     n_words - w0, n_eop - e0);
        end
        check_counters("sync_lost");
        send_frame(16'd12, 6, 0, 16'hBEEF, -1, 0);
        check_counters("sync_lost_recover");
    endtask

    task automatic test_ctrl_char();
        send_frame(16'd13, 7, 0, 16'hBEEF, 5, 2);
        check_counters("ctrl_char");
    endtask

    task automatic test_data_markers();
        int w0, k0;
        w0 = n_words; k0 = n_ok;
        send_frame(16'd13, 8, 1, 16'hBEEF, -1, 0);
        n_checks++;
        if ((n_words - w0) !== 125 || (n_ok - k0) !== 1) begin
            n_fail++;
            $display("FAIL markers got %0d words %0d ok want 125 words 1 ok", n_words - w0, n_ok - k0);
        end
        check_counters("markers");
    endtask

    task automatic test_ts_gap();
        int g0;
        do_reset();
        g0 = n_gap;
        send_frame(16'd10, 9, 0, 16'hBEEF, -1, 0);
        send_frame(16'd11, 10, 0, 16'hBEEF, -1, 0);
        send_frame(16'd20, 11, 0, 16'hBEEF, -1, 0);
        n_checks++;
        if ((n_gap - g0) !== 1) begin
            n_fail++;
            $display("FAIL ts_gap_count got %0d want 1", n_gap - g0);
        end
        do_reset();
        g0 = n_gap;
        send_frame(16'hFFFF, 12, 0, 16'hBEEF, -1, 0);
        send_frame(16'h0000, 13, 0, 16'hBEEF, -1, 0);
        n_checks++;
        if ((n_gap - g0) !== 0) begin
            n_fail++;
            $display("FAIL ts_wrap_gap got %0d want 0", n_gap - g0);
        end
        check_counters("ts_wrap");
    endtask

    task automatic test_reset_mid_frame();
        int r0;
        send_frame(16'd100, 14, 0, 16'hBEEF, -1, 0);
        r0 = n_err;
        send_frame(16'd200, 15, 0, 16'hBEEF, 60, 3);
        check_all_zero("mid_reset");
        send_frame(16'd300, 16, 0, 16'hBEEF, -1, 0);
        n_checks++;
        if ((n_err - r0) !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_err got %0d want 0", n_err - r0);
        end
        check_counters("mid_reset_recover");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_clean_frames();
        test_bad_ender();
        test_sync_lost();
        test_ctrl_char();
        test_data_markers();
        test_ts_gap();
        test_reset_mid_frame();
        idle(4);
        n_checks++;
        if (q_words.size() != 0 || q_stat.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d words %0d status pending want 0 0", q_words.size(), q_stat.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
